// File: rtl/line_mem_pkg.sv
// rtl/line_mem_pkg.sv - shared types and constants for the line memory model and its benches
package line_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam int LINE_W          = 256;
  localparam int OFFSET_W        = 5;
  localparam int DEFAULT_LATENCY = 10;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/line_memory_if.sv
// rtl/line_memory_if.sv - cache line request/ack bundle between data cache and line memory
interface line_memory_if;

  logic                             mem_enable_i;
  logic                             mem_write_i;
  logic [31:0]                      mem_addr_i;
  logic [line_mem_pkg::LINE_W-1:0]  mem_data_i;
  logic                             mem_ack_o;
  logic [line_mem_pkg::LINE_W-1:0]  mem_data_o;

  modport master (
    output mem_enable_i, mem_write_i, mem_addr_i, mem_data_i,
    input  mem_ack_o, mem_data_o
  );

  modport slave (
    input  mem_enable_i, mem_write_i, mem_addr_i, mem_data_i,
    output mem_ack_o, mem_data_o
  );

endinterface

// File: rtl/line_mem_array.sv
// rtl/line_mem_array.sv - single-port line storage, synchronous write and registered read
module line_mem_array
  import line_mem_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int IDX_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [DEPTH];

  // Storage contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[idx] <= wdata;
    end
  end

  // Read register holds the last read line until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/line_memory.sv
// rtl/line_memory.sv - fixed-latency cache line memory slave; LINE_MEM_STATS_EN adds read/write/busy counters
module line_memory
  import line_mem_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int DEPTH   = 512,
  parameter int IDX_W   = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  line_memory_if.slave mem
`ifdef LINE_MEM_STATS_EN
  ,
  output logic [31:0]  stat_reads_o,
  output logic [31:0]  stat_writes_o,
  output logic [31:0]  stat_busy_o
`endif
);

  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);
  localparam bit         DIRECT   = (LATENCY == 1);

  state_t              state;
  logic [7:0]          cnt;
  logic [IDX_W-1:0]    lat_idx;
  logic                lat_write;
  logic [LINE_W-1:0]   lat_data;
  logic                ack_q;

  logic                accept;
  logic                fire;
  logic [IDX_W-1:0]    req_idx;
  logic                req_write;
  logic [LINE_W-1:0]   req_data;
  logic                unused_addr;

  assign accept      = (state == IDLE) && mem.mem_enable_i;
  assign unused_addr = ^{mem.mem_addr_i[31:IDX_W+OFFSET_W], mem.mem_addr_i[OFFSET_W-1:0]};

  // In IDLE the live request feeds the array so a LATENCY of 1 can complete on the accept edge.
  always_comb begin
    req_idx   = lat_idx;
    req_write = lat_write;
    req_data  = lat_data;
    if (state == IDLE) begin
      req_idx   = mem.mem_addr_i[IDX_W+OFFSET_W-1:OFFSET_W];
      req_write = 1'b0;
      if (mem.mem_write_i) begin
        req_write = 1'b1;
      end
      req_data  = mem.mem_data_i;
    end
  end

  // The counter reaches zero on the edge that enters ACK, LATENCY-1 edges after acceptance.
  assign fire = (state == WAIT && cnt == 8'd1) || (accept && DIRECT);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_idx   <= '0;
      lat_write <= 1'b0;
      lat_data  <= '0;
      ack_q     <= 1'b0;
    end else begin
      ack_q <= fire;
      case (state)
        IDLE: begin
          if (accept) begin
            lat_idx   <= req_idx;
            lat_write <= req_write;
            lat_data  <= req_data;
            cnt       <= CNT_LOAD;
            state     <= DIRECT ? ACK : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            state <= ACK;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem.mem_ack_o = ack_q;

  line_mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk_i),
    .rst_n (rst_i),
    .en    (fire),
    .we    (req_write),
    .idx   (req_idx),
    .wdata (req_data),
    .rdata (mem.mem_data_o)
  );

`ifdef LINE_MEM_STATS_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stat_reads_o  <= '0;
      stat_writes_o <= '0;
      stat_busy_o   <= '0;
    end else begin
      if (state != IDLE) begin
        stat_busy_o <= sat_inc(stat_busy_o);
      end
      if (state == ACK) begin
        if (lat_write) begin
          stat_writes_o <= sat_inc(stat_writes_o);
        end else begin
          stat_reads_o <= sat_inc(stat_reads_o);
        end
      end
    end
  end
`endif

  a_write_known: assert property (@(posedge clk_i) disable iff (!rst_i)
    accept |-> !$isunknown(mem.mem_write_i));

endmodule
